// File: rtl/grn_pkg.sv
// Shared types for the grn dispatcher: FSM states and the {conf, transient} result pair.
package grn_pkg;

  localparam int unsigned PAIR_W  = 64;
  localparam int unsigned TRANS_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEED   = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    FINISH = 3'd4
  } t_disp_state;

  // One result slot of an output line; conf occupies the upper half.
  typedef struct packed {
    logic [31:0]        conf;
    logic [TRANS_W-1:0] transient;
  } t_pair;

endpackage

// File: rtl/grn_rr_arbiter.sv
// Round-robin arbiter: masked requests, one grant per cycle, pointer moves past each grant.
module grn_rr_arbiter #(
  parameter  int unsigned N     = 16,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     i_req,
  input  logic [N-1:0]     i_mask,
  input  logic             i_en,
  output logic [N-1:0]     o_grant_c,
  output logic [IDX_W-1:0] o_idx_c,
  output logic             o_valid_c
);

  logic [IDX_W-1:0] r_ptr;
  logic [N-1:0]     w_req;
  logic [31:0]      w_sum;
  logic [IDX_W-1:0] w_cand;

  assign w_req = i_req & ~i_mask;

  // First pending request found scanning upward from the pointer, wrapping at N.
  always_comb begin
    o_grant_c = '0;
    o_idx_c   = '0;
    o_valid_c = 1'b0;
    w_sum     = '0;
    w_cand    = '0;
    if (i_en) begin
      for (int unsigned k = 0; k < N; k++) begin
        w_sum  = 32'(r_ptr) + k;
        w_cand = (w_sum >= N) ? IDX_W'(w_sum - N) : IDX_W'(w_sum);
        if (!o_valid_c && w_req[w_cand]) begin
          o_valid_c         = 1'b1;
          o_idx_c           = w_cand;
          o_grant_c[w_cand] = 1'b1;
        end
      end
    end
  end

  // Pointer advances to the index after the granted engine.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (o_valid_c) begin
      r_ptr <= (32'(o_idx_c) == N - 1) ? '0 : o_idx_c + IDX_W'(1);
    end
  end

endmodule

// File: rtl/grn_dispatcher.sv
// Work scheduler for a bank of grn engines: seeds/re-issues states, packs results into lines.
// Optional GRN_DISP_STATS_EN adds stat_cycles / stat_stalls counters.
module grn_dispatcher
  import grn_pkg::*;
#(
  parameter  int unsigned BLOCKS_NUMBER = 16,
  parameter  int unsigned CONF_W        = 32,
  parameter  int unsigned CNT_W         = 32,
  parameter  int unsigned LINE_W        = 512,
  localparam int unsigned PAIRS         = LINE_W / PAIR_W,
  localparam int unsigned NP_W          = $clog2(PAIRS) + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [CNT_W-1:0]                cfg_total_states,
  output logic                            finish,
  output logic [BLOCKS_NUMBER-1:0]        blk_start,
  output logic [BLOCKS_NUMBER*CONF_W-1:0] blk_conf,
  output logic [BLOCKS_NUMBER-1:0]        blk_retire,
  input  logic [BLOCKS_NUMBER-1:0]        blk_done,
  input  logic [BLOCKS_NUMBER*32-1:0]     blk_transient,
  input  logic [BLOCKS_NUMBER*CONF_W-1:0] blk_conf_out,
  output logic                            wr_req,
  input  logic                            wr_ack,
  output logic [LINE_W-1:0]               wr_line,
  output logic [NP_W-1:0]                 wr_pairs
`ifdef GRN_DISP_STATS_EN
  ,
  output logic [31:0]                     stat_cycles,
  output logic [31:0]                     stat_stalls
`endif
);

  localparam int unsigned N      = BLOCKS_NUMBER;
  localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SLOT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int unsigned RUN_W  = $clog2(N + 1);

  t_disp_state             r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_total, r_next_state, w_seed_cnt;
  logic [RUN_W-1:0]        r_running;
  logic [N-1:0]            r_mask, r_blk_start, r_blk_retire;
  logic [N*CONF_W-1:0]     r_blk_conf;
  logic [LINE_W-1:0]       r_acc, r_wr_line;
  logic [NP_W-1:0]         r_acc_cnt, r_wr_pairs;
  logic                    r_wr_req, r_finish;

  logic                    w_accept_start, w_obuf_free, w_acc_full, w_bp, w_arb_en, w_xfer;
  logic [N-1:0]            w_grant;
  logic [IDX_W-1:0]        w_gnt_idx;
  logic                    w_gnt_valid;
  logic [SLOT_W-1:0]       w_slot;
  t_pair                   w_gnt_pair;

  assign w_accept_start = start & ((r_state == IDLE) | (r_state == FINISH));
  assign w_obuf_free    = ~r_wr_req | wr_ack;
  assign w_acc_full     = (r_acc_cnt == NP_W'(PAIRS));
  assign w_bp           = w_acc_full & ~w_obuf_free;
  assign w_arb_en       = (r_state == RUN) & ~w_bp;
  assign w_xfer         = w_obuf_free & (w_acc_full | ((r_state == DRAIN) & (r_acc_cnt != '0)));
  assign w_slot         = w_xfer ? '0 : r_acc_cnt[SLOT_W-1:0];
  assign w_seed_cnt     = (r_total < CNT_W'(N)) ? r_total : CNT_W'(N);

  grn_rr_arbiter #(.N(N)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (blk_done),
    .i_mask    (r_mask),
    .i_en      (w_arb_en),
    .o_grant_c (w_grant),
    .o_idx_c   (w_gnt_idx),
    .o_valid_c (w_gnt_valid)
  );

  // Result pair of the granted engine, conf zero-extended.
  always_comb begin
    w_gnt_pair           = '0;
    w_gnt_pair.conf      = 32'(blk_conf_out[w_gnt_idx*CONF_W +: CONF_W]);
    w_gnt_pair.transient = blk_transient[w_gnt_idx*32 +: 32];
  end

  // Next-state logic for the run sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, FINISH: if (start) w_state_nxt = SEED;
      SEED:         w_state_nxt = (r_total == '0) ? DRAIN : RUN;
      RUN:          if (r_running == '0) w_state_nxt = DRAIN;
      DRAIN:        if ((r_acc_cnt == '0) && !r_wr_req) w_state_nxt = FINISH;
      default:      w_state_nxt = IDLE;
    endcase
  end

  // State register, engine seeding, re-issue/retire on grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_finish     <= 1'b0;
      r_total      <= '0;
      r_next_state <= '0;
      r_running    <= '0;
      r_mask       <= '0;
      r_blk_start  <= '0;
      r_blk_retire <= '0;
      r_blk_conf   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_finish     <= (w_state_nxt == FINISH);
      r_mask       <= w_grant;
      r_blk_start  <= '0;
      r_blk_retire <= '0;
      if (w_accept_start) r_total <= cfg_total_states;
      if (r_state == SEED) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (CNT_W'(i) < r_total) begin
            r_blk_start[i]                  <= 1'b1;
            r_blk_conf[i*CONF_W +: CONF_W]  <= CONF_W'(i);
          end
        end
        r_next_state <= w_seed_cnt;
        r_running    <= RUN_W'(w_seed_cnt);
      end else if (w_gnt_valid) begin
        if (r_next_state < r_total) begin
          r_blk_start[w_gnt_idx]                  <= 1'b1;
          r_blk_conf[w_gnt_idx*CONF_W +: CONF_W]  <= CONF_W'(r_next_state);
          r_next_state                            <= r_next_state + CNT_W'(1);
        end else begin
          r_blk_retire[w_gnt_idx] <= 1'b1;
          r_running               <= r_running - RUN_W'(1);
        end
      end
    end
  end

  // Accumulator and double-buffered output line with req/ack handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_acc_cnt  <= '0;
      r_wr_req   <= 1'b0;
      r_wr_line  <= '0;
      r_wr_pairs <= '0;
    end else begin
      if (w_xfer) begin
        r_wr_req   <= 1'b1;
        r_wr_line  <= r_acc;
        r_wr_pairs <= r_acc_cnt;
        r_acc      <= '0;
        r_acc_cnt  <= '0;
      end else if (r_wr_req && wr_ack) begin
        r_wr_req <= 1'b0;
      end
      if (w_gnt_valid) begin
        r_acc[32'(w_slot)*PAIR_W +: PAIR_W] <= w_gnt_pair;
        r_acc_cnt <= (w_xfer ? NP_W'(0) : r_acc_cnt) + NP_W'(1);
      end
    end
  end

`ifdef GRN_DISP_STATS_EN
  logic [31:0] r_stat_cycles, r_stat_stalls;

  // Run-length and backpressure-stall counters, saturating.
  always_ff @(posedge clk) begin
    if (rst || w_accept_start) begin
      r_stat_cycles <= '0;
      r_stat_stalls <= '0;
    end else begin
      if (((r_state == SEED) || (r_state == RUN) || (r_state == DRAIN)) && (r_stat_cycles != '1))
        r_stat_cycles <= r_stat_cycles + 32'd1;
      if ((r_state == RUN) && w_bp && ((blk_done & ~r_mask) != '0) && (r_stat_stalls != '1))
        r_stat_stalls <= r_stat_stalls + 32'd1;
    end
  end

  assign stat_cycles = r_stat_cycles;
  assign stat_stalls = r_stat_stalls;
`endif

  assign finish     = r_finish;
  assign blk_start  = r_blk_start;
  assign blk_retire = r_blk_retire;
  assign blk_conf   = r_blk_conf;
  assign wr_req     = r_wr_req;
  assign wr_line    = r_wr_line;
  assign wr_pairs   = r_wr_pairs;

endmodule
